instruction_fetch_stage: RTL and testbench
==========================================

Name: instruction_fetch_stage

Overview:
- Front pipeline stage. Generates the fetch PC, issues one-outstanding requests to the instruction cache, and registers {PC, INSTRUCTION} for the decoding stage.
- Its output register is the IF/ID boundary: decode consumes INSTRUCTION_OUT/PC_OUT directly.
- Handles downstream stall, branch redirect from execute, and in-flight response discard after a redirect.

Parameters:
- RESET_PC, 32'h0000_0000, first fetch address after reset.
- NOP_INSTRUCTION, 32'h0000_0013, bubble encoding (addi x0,x0,0).

Ports:
- CLK  in  1  clock; all logic on posedge.
- RST  in  1  synchronous, active-high reset.
- STALL_FETCH_STAGE  in  1  hold the output register.
- BRANCH_TAKEN  in  1  redirect request from execute.
- BRANCH_TARGET  in  32  redirect address; bits [1:0] ignored, forced to 0.
- ICACHE_REQ_VALID  out  1  request valid.
- ICACHE_REQ_READY  in  1  cache accepts request.
- ICACHE_ADDRESS  out  32  request address, word aligned.
- ICACHE_RESP_VALID  in  1  response valid, 1-cycle pulse, no backpressure.
- ICACHE_RESP_DATA  in  32  instruction word.
- PC_OUT  out  32  PC of INSTRUCTION_OUT.
- INSTRUCTION_OUT  out  32  instruction to decode.
- INSTRUCTION_VALID  out  1  0 when output is a bubble.

Behaviour:
- Reset values:
  - fetch_pc=RESET_PC; state=IDLE; skid buffer empty.
  - PC_OUT=0; INSTRUCTION_OUT=NOP_INSTRUCTION; INSTRUCTION_VALID=0; ICACHE_REQ_VALID=0.
  - RST overrides every other input, including mid-transaction. Any response arriving in the first cycles after reset is ignored; IDLE does not sample the response.
- FSM states IDLE, REQUEST, WAIT, DISCARD:
  - IDLE: always moves to REQUEST on the next cycle.
  - REQUEST: ICACHE_REQ_VALID = !buf_valid and ICACHE_ADDRESS = fetch_pc, both driven from registered state. On VALID&&READY, go to WAIT.
  - WAIT: on RESP_VALID, the response is accepted, fetch_pc += 4 (wraps 32'hFFFF_FFFC -> 0), and the FSM returns to REQUEST.
  - DISCARD: the next RESP_VALID is dropped with no pc increment, then go to REQUEST.
- At most one request outstanding. A request is only issued while the skid buffer is empty, so an accepted response always finds the buffer empty or draining.
- Output register loads on every cycle with !STALL_FETCH_STAGE. Source priority:
  1. Redirect gives a bubble.
  2. Skid buffer valid gives the buffered {pc, instr}, and the buffer empties.
  3. Response accepted this cycle is bypassed, giving latency RESP_VALID -> INSTRUCTION_OUT of 1 cycle.
  4. Otherwise a bubble.
- Bubble = {PC_OUT=0, INSTRUCTION_OUT=NOP_INSTRUCTION, INSTRUCTION_VALID=0}.
- STALL high: the output register holds. An accepted response is written to the skid buffer.
- BRANCH_TAKEN has priority over stall and response:
  - fetch_pc <= {BRANCH_TARGET[31:2],2'b00}; buffer invalidated; output register <= bubble (even if stalled).
  - Next state:
    - REQUEST without handshake this cycle: REQUEST, address replaced next cycle.
    - REQUEST with handshake this cycle: DISCARD.
    - WAIT without RESP_VALID: DISCARD.
    - WAIT with RESP_VALID: the response is dropped; REQUEST.
    - DISCARD without RESP_VALID: DISCARD with the new target.
    - DISCARD with RESP_VALID: REQUEST.
    - IDLE: REQUEST.
- Back-to-back redirects: the last one wins.
- Steady state with a 1-cycle cache delivers one instruction every 2 cycles.

Optional Feature:
- Macro FETCH_PERF_COUNTERS_EN.
- Defined: adds outputs BUBBLE_COUNT[31:0] and REDIRECT_COUNT[31:0].
  - BUBBLE_COUNT increments when the output register loads a bubble.
  - REDIRECT_COUNT increments on each BRANCH_TAKEN cycle.
  - Both reset to 0, saturate at 32'hFFFF_FFFF, and are unaffected by stall.
- Undefined: ports and logic are absent; behaviour is otherwise identical.

Decomposition:
- Package riscv_fetch_pkg holds:
  - NOP_INSTRUCTION constant and PC_STEP = 4.
  - fetch_state_t enum {IDLE, REQUEST, WAIT, DISCARD}.
  - fetch_entry_t struct {pc[31:0], instr[31:0]}.
- Sub-module fetch_skid_buffer: a 1-entry register with write, read, flush, and valid.
- The FSM and output register stay in the top module.

Test Plan:
- Reset, then READY=1 and the cache answers 1 cycle after accept with words 0xA0/0xA4/0xA8 -> PC_OUT 0x0/0x4/0x8 with VALID=1; ICACHE_ADDRESS sequence 0x0, 0x4, 0x8.
- STALL high for 4 cycles while the response for 0x4 arrives -> output holds 0x0; no new request while the buffer is full; at stall release PC_OUT=0x4 then 0x8, nothing lost or duplicated.
- BRANCH_TAKEN with target 0x102 while in WAIT -> DISCARD; the stale response is dropped; next request address is 0x100; output shows a bubble then PC 0x100.
- BRANCH_TAKEN in the same cycle as RESP_VALID -> the response is dropped; the next cycle requests the target; INSTRUCTION_OUT = 0x13 with VALID=0.
- fetch_pc=0xFFFF_FFFC -> the next request address is 0x0000_0000.
- RST asserted in WAIT, with the response arriving one cycle later -> the response is ignored; the first request after reset goes to RESET_PC; outputs hold reset values. With FETCH_PERF_COUNTERS_EN, counters read 0 after reset and match the expected bubble and redirect totals at the end.

Source files
------------

// File: rtl/instruction_fetch_stage_pkg.sv
// Shared types and constants for the instruction fetch stage.
package riscv_fetch_pkg;

  localparam logic [31:0] NOP_INSTRUCTION = 32'h0000_0013;
  localparam logic [31:0] PC_STEP         = 32'd4;

  typedef enum logic [1:0] {IDLE, REQUEST, WAIT, DISCARD} fetch_state_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/instruction_fetch_stage_if.sv
// Instruction-cache request/response bundle between fetch (master) and cache (slave).
interface instruction_fetch_stage_if;
  logic        ICACHE_REQ_VALID;
  logic        ICACHE_REQ_READY;
  logic [31:0] ICACHE_ADDRESS;
  logic        ICACHE_RESP_VALID;
  logic [31:0] ICACHE_RESP_DATA;

  modport master (
    output ICACHE_REQ_VALID, ICACHE_ADDRESS,
    input  ICACHE_REQ_READY, ICACHE_RESP_VALID, ICACHE_RESP_DATA
  );

  modport slave (
    input  ICACHE_REQ_VALID, ICACHE_ADDRESS,
    output ICACHE_REQ_READY, ICACHE_RESP_VALID, ICACHE_RESP_DATA
  );
endinterface

// File: rtl/instruction_fetch_stage_skid_buffer.sv
// One-entry holding register for a response that arrives while decode is stalled.
module fetch_skid_buffer
  import riscv_fetch_pkg::*;
(
  input  logic         CLK,
  input  logic         RST,
  input  logic         wr_en,
  input  logic         rd_en,
  input  logic         flush,
  input  fetch_entry_t wr_data,
  output fetch_entry_t rd_data,
  output logic         valid
);

  always_ff @(posedge CLK) begin
    if (RST || flush) begin
      valid <= 1'b0;
    end else if (wr_en) begin
      valid   <= 1'b1;
      rd_data <= wr_data;
    end else if (rd_en) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/instruction_fetch_stage.sv
// Fetch stage: PC generation, single-outstanding icache requests, IF/ID register.
// Optional FETCH_PERF_COUNTERS_EN adds BUBBLE_COUNT / REDIRECT_COUNT outputs.
module instruction_fetch_stage
  import riscv_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC        = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTRUCTION = riscv_fetch_pkg::NOP_INSTRUCTION
) (
  input  logic                       CLK,
  input  logic                       RST,
  input  logic                       STALL_FETCH_STAGE,
  input  logic                       BRANCH_TAKEN,
  input  logic [31:0]                BRANCH_TARGET,
  instruction_fetch_stage_if.master  icache,
  output logic [31:0]                PC_OUT,
  output logic [31:0]                INSTRUCTION_OUT,
  output logic                       INSTRUCTION_VALID
`ifdef FETCH_PERF_COUNTERS_EN
  ,
  output logic [31:0]                BUBBLE_COUNT,
  output logic [31:0]                REDIRECT_COUNT
`endif
);

  fetch_state_t state, state_nxt;
  logic [31:0]  fetch_pc, fetch_pc_nxt;
  fetch_entry_t out_q, buf_q, resp_entry;
  logic         out_vld;
  logic         buf_vld, hs, resp_acc, out_load, out_bubble;

  assign icache.ICACHE_REQ_VALID = (state == REQUEST) && !buf_vld;
  assign icache.ICACHE_ADDRESS   = fetch_pc;

  assign hs         = icache.ICACHE_REQ_VALID && icache.ICACHE_REQ_READY;
  // A redirect in the same cycle as the response kills it.
  assign resp_acc   = (state == WAIT) && icache.ICACHE_RESP_VALID && !BRANCH_TAKEN;
  assign resp_entry = '{pc: fetch_pc, instr: icache.ICACHE_RESP_DATA};
  assign out_load   = BRANCH_TAKEN || !STALL_FETCH_STAGE;
  assign out_bubble = BRANCH_TAKEN || (!buf_vld && !resp_acc);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    state_nxt = REQUEST;
      REQUEST: if (hs) state_nxt = BRANCH_TAKEN ? DISCARD : WAIT;
      WAIT: begin
        if (icache.ICACHE_RESP_VALID) state_nxt = REQUEST;
        else if (BRANCH_TAKEN)        state_nxt = DISCARD;
      end
      DISCARD: if (icache.ICACHE_RESP_VALID) state_nxt = REQUEST;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    fetch_pc_nxt = fetch_pc;
    if (BRANCH_TAKEN)  fetch_pc_nxt = BRANCH_TARGET & 32'hFFFF_FFFC;
    else if (resp_acc) fetch_pc_nxt = fetch_pc + PC_STEP;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state    <= IDLE;
      fetch_pc <= RESET_PC;
      out_q    <= '{pc: 32'h0, instr: NOP_INSTRUCTION};
      out_vld  <= 1'b0;
    end else begin
      state    <= state_nxt;
      fetch_pc <= fetch_pc_nxt;
      if (out_load) begin
        if (out_bubble) begin
          out_q   <= '{pc: 32'h0, instr: NOP_INSTRUCTION};
          out_vld <= 1'b0;
        end else begin
          out_q   <= buf_vld ? buf_q : resp_entry;
          out_vld <= 1'b1;
        end
      end
    end
  end

  fetch_skid_buffer u_skid (
    .CLK     (CLK),
    .RST     (RST),
    .wr_en   (resp_acc && STALL_FETCH_STAGE),
    .rd_en   (buf_vld && !STALL_FETCH_STAGE && !BRANCH_TAKEN),
    .flush   (BRANCH_TAKEN),
    .wr_data (resp_entry),
    .rd_data (buf_q),
    .valid   (buf_vld)
  );

  assign PC_OUT            = out_q.pc;
  assign INSTRUCTION_OUT   = out_q.instr;
  assign INSTRUCTION_VALID = out_vld;

`ifdef FETCH_PERF_COUNTERS_EN
  always_ff @(posedge CLK) begin
    if (RST) begin
      BUBBLE_COUNT   <= 32'h0;
      REDIRECT_COUNT <= 32'h0;
    end else begin
      if (out_load && out_bubble && BUBBLE_COUNT != 32'hFFFF_FFFF)
        BUBBLE_COUNT <= BUBBLE_COUNT + 32'd1;
      if (BRANCH_TAKEN && REDIRECT_COUNT != 32'hFFFF_FFFF)
        REDIRECT_COUNT <= REDIRECT_COUNT + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_instruction_fetch_stage.sv
// Randomized bench for instruction_fetch_stage with an in-bench fetch model and cache responder.
module tb_instruction_fetch_stage;
  import riscv_fetch_pkg::*;

  logic        CLK = 1'b0;
  logic        RST, STALL, BR;
  logic [31:0] TGT;
  logic [31:0] PC_OUT, INSTRUCTION_OUT;
  logic        INSTRUCTION_VALID;
`ifdef FETCH_PERF_COUNTERS_EN
  logic [31:0] BUBBLE_COUNT, REDIRECT_COUNT;
`endif

  instruction_fetch_stage_if ic();

  always #5 CLK = ~CLK;

  instruction_fetch_stage dut (
    .CLK               (CLK),
    .RST               (RST),
    .STALL_FETCH_STAGE (STALL),
    .BRANCH_TAKEN      (BR),
    .BRANCH_TARGET     (TGT),
    .icache            (ic),
    .PC_OUT            (PC_OUT),
    .INSTRUCTION_OUT   (INSTRUCTION_OUT),
    .INSTRUCTION_VALID (INSTRUCTION_VALID)
`ifdef FETCH_PERF_COUNTERS_EN
    ,
    .BUBBLE_COUNT      (BUBBLE_COUNT),
    .REDIRECT_COUNT    (REDIRECT_COUNT)
`endif
  );

  int tests = 0;
  int fails = 0;

  // Model: "fresh" = first cycle after reset, "pend" = a request is in flight,
  // "drop" = the in-flight response belongs to a redirected-away path.
  bit           m_known = 0;
  bit           m_fresh, m_pend, m_drop, m_ov;
  logic [31:0]  m_pc, m_opc, m_oin, m_bub, m_red;
  fetch_entry_t m_q[$];

  int          c_cnt = 0, c_delay = 1;
  logic [31:0] c_addr = 0;
  logic [31:0] hs_log[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic bit m_req();
    return !m_fresh && !m_pend && (m_q.size() == 0);
  endfunction

  task automatic m_bubble();
    m_opc = 32'h0; m_oin = 32'h13; m_ov = 1'b0;
    if (m_bub != 32'hFFFF_FFFF) m_bub++;
  endtask

  task automatic model_step();
    bit hs, rv, acc, np;
    fetch_entry_t e;
    if (RST) begin
      m_known = 1; m_fresh = 1; m_pend = 0; m_drop = 0;
      m_pc = 32'h0; m_q.delete();
      m_opc = 32'h0; m_oin = 32'h13; m_ov = 0; m_bub = 0; m_red = 0;
    end else begin
      hs  = m_req() && ic.ICACHE_REQ_READY;
      rv  = ic.ICACHE_RESP_VALID;
      acc = m_pend && !m_drop && rv && !BR;
      np  = m_pend ? !rv : hs;
      m_drop  = np && (BR || m_drop);
      m_pend  = np;
      m_fresh = 0;
      if (BR) m_bubble();
      else if (!STALL) begin
        if (m_q.size() > 0) begin
          e = m_q.pop_front();
          m_opc = e.pc; m_oin = e.instr; m_ov = 1;
        end else if (acc) begin
          m_opc = m_pc; m_oin = ic.ICACHE_RESP_DATA; m_ov = 1;
        end else m_bubble();
      end else if (acc) begin
        e.pc = m_pc; e.instr = ic.ICACHE_RESP_DATA;
        m_q.push_back(e);
      end
      if (BR) begin
        m_q.delete();
        m_pc = {TGT[31:2], 2'b00};
        if (m_red != 32'hFFFF_FFFF) m_red++;
      end else if (acc) m_pc = m_pc + 32'd4;
    end
  endtask

  // One clock: compare at negedge, advance model and cache, land #1 after posedge.
  task automatic tick();
    @(negedge CLK);
    if (m_known) begin
      chk("req_valid", ic.ICACHE_REQ_VALID, 32'(m_req()));
      if (m_req()) chk("address", ic.ICACHE_ADDRESS, m_pc);
      chk("pc_out", PC_OUT, m_opc);
      chk("instr_out", INSTRUCTION_OUT, m_oin);
      chk("instr_valid", INSTRUCTION_VALID, 32'(m_ov));
`ifdef FETCH_PERF_COUNTERS_EN
      chk("bubble_count", BUBBLE_COUNT, m_bub);
      chk("redirect_count", REDIRECT_COUNT, m_red);
`endif
    end
    if (ic.ICACHE_REQ_VALID && ic.ICACHE_REQ_READY && !RST) begin
      c_cnt  = c_delay;
      c_addr = ic.ICACHE_ADDRESS;
      hs_log.push_back(c_addr);
    end
    model_step();
    @(posedge CLK); #1;
    ic.ICACHE_RESP_VALID = (c_cnt == 1);
    ic.ICACHE_RESP_DATA  = (c_cnt == 1) ? c_addr + 32'hA0 : $urandom;
    if (c_cnt > 0) c_cnt--;
  endtask

  task automatic wait_valid(input string nm, input logic [31:0] pc, input logic [31:0] ins);
    int n = 0;
    do begin tick(); n++; end while (!INSTRUCTION_VALID && n < 20);
    chk({nm, "_valid"}, INSTRUCTION_VALID, 1);
    chk({nm, "_pc"}, PC_OUT, pc);
    chk({nm, "_instr"}, INSTRUCTION_OUT, ins);
  endtask

  task automatic wait_req(input string nm, input logic [31:0] addr);
    int n = 0;
    while (!ic.ICACHE_REQ_VALID && n < 20) begin tick(); n++; end
    chk({nm, "_req"}, ic.ICACHE_REQ_VALID, 1);
    chk({nm, "_addr"}, ic.ICACHE_ADDRESS, addr);
  endtask

  initial begin
    int n;
    RST = 1; STALL = 0; BR = 0; TGT = 0;
    ic.ICACHE_REQ_READY = 1; ic.ICACHE_RESP_VALID = 0; ic.ICACHE_RESP_DATA = 0;
    tick();
    RST = 0;
    chk("rst_pc_out", PC_OUT, 32'h0);
    chk("rst_instr", INSTRUCTION_OUT, 32'h13);
    chk("rst_valid", INSTRUCTION_VALID, 0);
    chk("rst_req_valid", ic.ICACHE_REQ_VALID, 0);
`ifdef FETCH_PERF_COUNTERS_EN
    chk("rst_bubbles", BUBBLE_COUNT, 0);
    chk("rst_redirects", REDIRECT_COUNT, 0);
`endif

    // Streaming, then a 4-cycle stall across the response for 0x4.
    wait_valid("first", 32'h0, 32'hA0);
    STALL = 1;
    repeat (4) begin
      tick();
      chk("stall_hold_pc", PC_OUT, 32'h0);
      chk("stall_hold_valid", INSTRUCTION_VALID, 1);
      chk("stall_no_req", ic.ICACHE_REQ_VALID, 0);
    end
    STALL = 0;
    wait_valid("after_stall", 32'h4, 32'hA4);
    wait_valid("third", 32'h8, 32'hA8);
    chk("addr_seq_len", hs_log.size(), 3);
    if (hs_log.size() >= 3) begin
      chk("addr_seq0", hs_log[0], 32'h0);
      chk("addr_seq1", hs_log[1], 32'h4);
      chk("addr_seq2", hs_log[2], 32'h8);
    end

    // Redirect while waiting on a slow response.
    c_delay = 3;
    tick();
    BR = 1; TGT = 32'h102;
    tick();
    BR = 0; c_delay = 1;
    chk("redir_bubble_valid", INSTRUCTION_VALID, 0);
    chk("redir_bubble_instr", INSTRUCTION_OUT, 32'h13);
    wait_req("redir", 32'h100);
    wait_valid("target", 32'h100, 32'h1A0);

    // Redirect in the same cycle as the response.
    n = 0;
    while (!ic.ICACHE_RESP_VALID && n < 20) begin tick(); n++; end
    chk("resp_seen", ic.ICACHE_RESP_VALID, 1);
    BR = 1; TGT = 32'h200;
    tick();
    BR = 0;
    chk("same_req", ic.ICACHE_REQ_VALID, 1);
    chk("same_addr", ic.ICACHE_ADDRESS, 32'h200);
    chk("same_instr", INSTRUCTION_OUT, 32'h13);
    chk("same_valid", INSTRUCTION_VALID, 0);

    // Wrap of the fetch PC; target low bits are ignored.
    BR = 1; TGT = 32'hFFFF_FFFF;
    tick();
    BR = 0;
    wait_valid("top", 32'hFFFF_FFFC, 32'h0000_009C);
    wait_req("wrap", 32'h0);
`ifdef FETCH_PERF_COUNTERS_EN
    chk("redirect_total", REDIRECT_COUNT, 3);
`endif

    // Reset while in WAIT; response lands in the first cycle after reset.
    c_delay = 2;
    tick();
    RST = 1;
    tick();
    RST = 0;
    chk("rst2_resp_present", ic.ICACHE_RESP_VALID, 1);
    chk("rst2_valid", INSTRUCTION_VALID, 0);
    chk("rst2_pc", PC_OUT, 32'h0);
    chk("rst2_req_valid", ic.ICACHE_REQ_VALID, 0);
`ifdef FETCH_PERF_COUNTERS_EN
    chk("rst2_redirects", REDIRECT_COUNT, 0);
    chk("rst2_bubbles", BUBBLE_COUNT, 0);
`endif
    tick();
    chk("rst2_first_req", ic.ICACHE_REQ_VALID, 1);
    chk("rst2_first_addr", ic.ICACHE_ADDRESS, 32'h0);
    chk("rst2_out_valid", INSTRUCTION_VALID, 0);

    // Randomized traffic against the model.
    repeat (3000) begin
      RST   = ($urandom % 100) < 1;
      STALL = ($urandom % 100) < 30;
      BR    = ($urandom % 100) < 6;
      TGT   = $urandom;
      ic.ICACHE_REQ_READY = ($urandom % 100) < 70;
      c_delay = $urandom_range(1, 3);
      tick();
    end
    RST = 0; STALL = 0; BR = 0;
    repeat (10) tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
